// File: rtl/piso_bit_feeder_pkg.sv
// Shared definitions for the parallel-in/serial-out bit feeder.
//   state_e     : FSM state encoding (ST_IDLE, ST_SHIFT)
//   WORDS_CNT_W : width of the words_sent counter
package piso_bit_feeder_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int WORDS_CNT_W = 16;

endpackage

// File: rtl/piso_bit_feeder.sv
// piso_bit_feeder
//   Takes WIDTH-bit words over a valid/ready handshake and sends them out one bit
//   per clock on x. x feeds the serial input of the sequence detector. A one-word
//   holding register lets consecutive words follow each other with no gap bit, so
//   patterns that cross a word boundary stay contiguous.
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   din        : parallel word
//   din_valid  : din holds a word
//   din_ready  : word accepted this cycle when din_valid is also high
//   x          : serial data bit (registered)
//   x_valid    : x carries a real data bit (registered)
//   busy       : shifting, or holding register occupied
//   words_sent : number of words fully shifted out, wraps at 16 bits
module piso_bit_feeder
    import piso_bit_feeder_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       din,
    input  logic                   din_valid,
    output logic                   din_ready,
    output logic                   x,
    output logic                   x_valid,
    output logic                   busy,
    output logic [WORDS_CNT_W-1:0] words_sent
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    // Bit that goes out on x when the shift register is at the head of a word.
    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        if (MSB_FIRST)
            return v[WIDTH-1];
        else
            return v[0];
    endfunction

    // Advance the shift register by one bit toward the head.
    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
        if (MSB_FIRST)
            return {v[WIDTH-2:0], 1'b0};
        else
            return {1'b0, v[WIDTH-1:1]};
    endfunction

    state_e           state;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hold;
    logic             hold_full;

    state_e                 nxt_state;
    logic [WIDTH-1:0]       nxt_sreg;
    logic [CNT_W-1:0]       nxt_cnt;
    logic [WIDTH-1:0]       nxt_hold;
    logic                   nxt_hold_full;
    logic [WORDS_CNT_W-1:0] nxt_words;
    logic                   xfer;

    // Ready depends only on registered state so upstream never sees a
    // combinational path from its own valid back to ready.
    assign din_ready = ~hold_full;
    assign xfer      = din_valid & din_ready;
    assign busy      = (state == ST_SHIFT) | hold_full;

    always_comb begin
        nxt_state     = state;
        nxt_sreg      = sreg;
        nxt_cnt       = cnt;
        nxt_hold      = hold;
        nxt_hold_full = hold_full;
        nxt_words     = words_sent;

        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    nxt_sreg  = din;
                    nxt_cnt   = '0;
                    nxt_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt == CNT_LAST) begin
                    nxt_words = words_sent + WORDS_CNT_W'(1);
                    if (hold_full) begin
                        // din_ready is low here, so din cannot also be taken.
                        nxt_sreg      = hold;
                        nxt_hold_full = 1'b0;
                        nxt_cnt       = '0;
                    end else if (xfer) begin
                        // Direct reload keeps the bit stream gap-free.
                        nxt_sreg = din;
                        nxt_cnt  = '0;
                    end else begin
                        nxt_state = ST_IDLE;
                    end
                end else begin
                    nxt_sreg = shift_one(sreg);
                    nxt_cnt  = cnt + CNT_W'(1);
                    if (xfer) begin
                        nxt_hold      = din;
                        nxt_hold_full = 1'b1;
                    end
                end
            end
            default: begin
                nxt_state = ST_IDLE;
            end
        endcase
    end

    // x/x_valid are registered from the next-state values, so the detector
    // sees flop outputs only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sreg       <= '0;
            cnt        <= '0;
            hold_full  <= 1'b0;
            words_sent <= '0;
            x          <= IDLE_BIT;
            x_valid    <= 1'b0;
        end else begin
            state      <= nxt_state;
            sreg       <= nxt_sreg;
            cnt        <= nxt_cnt;
            hold_full  <= nxt_hold_full;
            words_sent <= nxt_words;
            x          <= (nxt_state == ST_SHIFT) ? head_bit(nxt_sreg) : IDLE_BIT;
            x_valid    <= (nxt_state == ST_SHIFT);
        end
    end

    // Hold contents are only meaningful while hold_full is set.
    always_ff @(posedge clk) begin
        hold <= nxt_hold;
    end

endmodule
